// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
//   Shared definitions for the reset sequencer:
//   - seq_state_t   : sequencer state, fixed encodings 0..3 (also driven on o_state)
//   - DEF_*         : default parameter values
//   - counter_width : width of the cycle counter given the cycle parameters
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_LOCKS      = 3;
  localparam int DEF_NUM_DOMAINS    = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES    = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  // One extra bit above the largest limit so the counter can always
  // reach the compare value without wrapping.
  function automatic int counter_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_bit_synchronizer.sv
// bit_synchronizer
//   Single-bit multi-flop synchroniser for an asynchronous level input.
//   Parameters: STAGES (>= 2) flop chain depth.
//   Ports:
//     clock : destination clock
//     reset : synchronous active-high reset, clears the chain to 0
//     d     : asynchronous input
//     q     : synchronised output (last flop of the chain)
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-on / clock-loss reset sequencer. Pulses the MMCM reset, waits for
//   all MMCM locks, then releases the downstream domain resets one at a time
//   (bit 0 first), HOLD_CYCLES apart. Any lock loss during release or run
//   re-asserts every domain reset and restarts from WAIT_LOCK.
//
//   Optional build macro: RESET_SEQUENCER_TIMEOUT_EN
//     defined   : WAIT_LOCK watchdog; on expiry the missing locks are latched
//                 into o_fault (sticky until reset) and the MMCM reset is retried.
//     undefined : no watchdog, o_fault tied to 0.
//
//   Ports:
//     clock       : free-running board clock
//     reset       : synchronous active-high reset
//     i_locked    : raw asynchronous MMCM LOCKED inputs [NUM_LOCKS]
//     o_pll_reset : MMCM RST, active-high
//     o_reset     : per-domain resets, active-high [NUM_DOMAINS]
//     o_all_ready : high only in RUN
//     o_state     : current state encoding (seq_state_t)
//     o_fault     : sticky per-lock timeout flags [NUM_LOCKS]
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_LOCKS      = DEF_NUM_LOCKS,
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_LOCKS-1:0]   i_locked,
  output logic                   o_pll_reset,
  output logic [NUM_DOMAINS-1:0] o_reset,
  output logic                   o_all_ready,
  output logic [1:0]             o_state,
  output logic [NUM_LOCKS-1:0]   o_fault
);

  localparam int CW = counter_width(PLL_RST_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int KW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_DOMAINS - 1);

  seq_state_t             state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;
  logic [KW-1:0]          k;
  logic [NUM_LOCKS-1:0]   lk;
  logic                   all_locked;
  logic                   pll_reset_q;
  logic [NUM_DOMAINS-1:0] reset_q;
  logic                   all_ready_q;

  for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_sync
    bit_synchronizer #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (i_locked[i]),
      .q    (lk[i])
    );
  end

  assign all_locked = &lk;
  // Saturating increment: the counter never wraps back to a compare value.
  assign cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic [NUM_LOCKS-1:0] fault_q;
  assign o_fault = fault_q;
`else
  assign o_fault = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_PLL_RST;
      cnt         <= '0;
      k           <= '0;
      pll_reset_q <= 1'b1;
      reset_q     <= '1;
      all_ready_q <= 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      fault_q     <= '0;
`endif
    end else if ((state == ST_RELEASE || state == ST_RUN) && !all_locked) begin
      // Lock loss: re-reset everything; a partial release never resumes.
      state       <= ST_WAIT_LOCK;
      cnt         <= '0;
      k           <= '0;
      reset_q     <= '1;
      all_ready_q <= 1'b0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
            state       <= ST_WAIT_LOCK;
            pll_reset_q <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            fault_q     <= fault_q | ~lk;
            state       <= ST_PLL_RST;
            pll_reset_q <= 1'b1;
            cnt         <= '0;
          end else if (all_locked) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            k     <= '0;
          end else begin
            cnt <= cnt_inc;
          end
`else
          if (all_locked) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            k     <= '0;
          end
`endif
        end
        ST_RELEASE: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            reset_q[k] <= 1'b0;
            cnt        <= '0;
            if (k == K_LAST) begin
              state       <= ST_RUN;
              all_ready_q <= 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RUN: begin
          // Stay here; lock loss is handled above.
        end
        default: begin
          state <= ST_PLL_RST;
        end
      endcase
    end
  end

  assign o_pll_reset = pll_reset_q;
  assign o_reset     = reset_q;
  assign o_all_ready = all_ready_q;
  assign o_state     = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer with NUM_LOCKS=3, NUM_DOMAINS=3,
//   SYNC_STAGES=2, PLL_RST_CYCLES=8, HOLD_CYCLES=4, TIMEOUT_CYCLES=64.
//   Cycle 0 is the cycle following the last edge that saw reset high.
//   Inputs are driven and outputs sampled at the falling edge.
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic [2:0] i_locked;
  logic       o_pll_reset;
  logic [2:0] o_reset;
  logic       o_all_ready;
  logic [1:0] o_state;
  logic [2:0] o_fault;

  int pass_cnt  = 0;
  int total_cnt = 0;

  reset_sequencer #(
    .NUM_LOCKS     (3),
    .NUM_DOMAINS   (3),
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(8),
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_locked   (i_locked),
    .o_pll_reset(o_pll_reset),
    .o_reset    (o_reset),
    .o_all_ready(o_all_ready),
    .o_state    (o_state),
    .o_fault    (o_fault)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // observed vector: {state, reset[2:0], all_ready, pll_reset, fault[2:0]}
  logic [9:0] obs;
  assign obs = {o_state, o_reset, o_all_ready, o_pll_reset, o_fault};

  function automatic logic [9:0] pack(logic [1:0] st, logic [2:0] rst, logic rdy,
                                      logic pll, logic [2:0] flt);
    return {st, rst, rdy, pll, flt};
  endfunction

  // Domain resets as a function of cycles since entering RELEASE (HOLD=4).
  function automatic logic [2:0] exp_rst(int rr);
    if (rr < 4)  return 3'b111;
    if (rr < 8)  return 3'b110;
    if (rr < 12) return 3'b100;
    return 3'b000;
  endfunction

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset;
    logic [9:0] e;
    reset    = 1'b1;
    i_locked = 3'b000;
    repeat (3) step();
    e = pack(2'd0, 3'b111, 1'b0, 1'b1, 3'b000);
    total_cnt++;
    if (obs !== e) $display("FAIL reset_state obs=%b exp=%b", obs, e);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_powerup;
    logic [9:0] e;
    logic [1:0] st;
    logic [2:0] rst;
    for (int c = 0; c <= 40; c++) begin
      i_locked = (c >= 20) ? 3'b111 : 3'b000;
      st  = (c <= 7) ? 2'd0 : (c <= 22) ? 2'd1 : (c <= 34) ? 2'd2 : 2'd3;
      rst = (c < 27) ? 3'b111 : (c < 31) ? 3'b110 : (c < 35) ? 3'b100 : 3'b000;
      e = pack(st, rst, c >= 35, c <= 7, 3'b000);
      total_cnt++;
      if (obs !== e) $display("FAIL powerup c=%0d obs=%b exp=%b", c, obs, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_run_dropout;
    logic [9:0] e;
    int rr;
    for (int r = 0; r <= 17; r++) begin
      i_locked = (r == 0) ? 3'b101 : 3'b111;
      step();
      if (r + 1 <= 2) e = pack(2'd3, 3'b000, 1'b1, 1'b0, 3'b000);
      else if (r + 1 == 3) e = pack(2'd1, 3'b111, 1'b0, 1'b0, 3'b000);
      else begin
        rr = r + 1 - 4;
        e = pack((rr < 12) ? 2'd2 : 2'd3, exp_rst(rr), rr >= 12, 1'b0, 3'b000);
      end
      total_cnt++;
      if (obs !== e) $display("FAIL run_dropout c=%0d obs=%b exp=%b", r + 1, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_release_drop;
    logic [9:0] e;
    int c;
    int rr;
    for (int r = 0; r <= 25; r++) begin
      i_locked = (r == 0 || r == 8) ? 3'b110 : 3'b111;
      step();
      c = r + 1;
      if (c <= 2) e = pack(2'd3, 3'b000, 1'b1, 1'b0, 3'b000);
      else if (c == 3 || c == 11) e = pack(2'd1, 3'b111, 1'b0, 1'b0, 3'b000);
      else begin
        rr = (c <= 10) ? c - 4 : c - 12;
        e = pack((rr < 12) ? 2'd2 : 2'd3, exp_rst(rr), rr >= 12, 1'b0, 3'b000);
      end
      total_cnt++;
      if (obs !== e) $display("FAIL release_drop c=%0d obs=%b exp=%b", c, obs, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_in_run;
    logic [9:0] e;
    reset = 1'b1;
    step();
    e = pack(2'd0, 3'b111, 1'b0, 1'b1, 3'b000);
    total_cnt++;
    if (obs !== e) $display("FAIL reset_in_run obs=%b exp=%b", obs, e);
    else pass_cnt++;
    reset = 1'b0;
  endtask

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout;
    logic [9:0] e;
    logic       chk;
    i_locked = 3'b011;
    for (int c = 0; c <= 95; c++) begin
      if (c == 80) i_locked = 3'b111;
      chk = 1'b1;
      case (c)
        71:      e = pack(2'd1, 3'b111, 1'b0, 1'b0, 3'b000);
        72:      e = pack(2'd0, 3'b111, 1'b0, 1'b1, 3'b100);
        79:      e = pack(2'd0, 3'b111, 1'b0, 1'b1, 3'b100);
        80:      e = pack(2'd1, 3'b111, 1'b0, 1'b0, 3'b100);
        94:      e = pack(2'd2, 3'b100, 1'b0, 1'b0, 3'b100);
        95:      e = pack(2'd3, 3'b000, 1'b1, 1'b0, 3'b100);
        default: begin e = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        total_cnt++;
        if (obs !== e) $display("FAIL timeout c=%0d obs=%b exp=%b", c, obs, e);
        else pass_cnt++;
      end
      step();
    end
  endtask
`else
  task automatic test_no_timeout;
    logic [9:0] e;
    logic       chk;
    i_locked = 3'b011;
    for (int c = 0; c <= 200; c++) begin
      chk = 1'b1;
      case (c)
        5:            e = pack(2'd0, 3'b111, 1'b0, 1'b1, 3'b000);
        71, 72, 200:  e = pack(2'd1, 3'b111, 1'b0, 1'b0, 3'b000);
        default: begin e = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        total_cnt++;
        if (obs !== e) $display("FAIL no_timeout c=%0d obs=%b exp=%b", c, obs, e);
        else pass_cnt++;
      end
      step();
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    i_locked = 3'b000;
    test_reset();
    test_powerup();
    test_run_dropout();
    test_release_drop();
    test_reset_in_run();
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and clock-loss reset sequencer for the FPGA shell. It drives the MMCM reset, waits for every MMCM lock, then releases reset to each downstream domain in a fixed order (core, DRAM controller, UART, Ethernet, …). It replaces ad-hoc `reset || ~locked` gating with an ordered, glitch-filtered release and automatic re-sequencing on lock loss. It runs on the free-running board clock.

## Interface
Parameters:
- `NUM_LOCKS`, default 3: number of MMCM lock inputs; at least 1.
- `NUM_DOMAINS`, default 4: number of sequenced reset outputs; at least 1.
- `SYNC_STAGES`, default 2: synchroniser depth on lock inputs; at least 2.
- `PLL_RST_CYCLES`, default 16: `o_pll_reset` pulse length; at least 1.
- `HOLD_CYCLES`, default 1024: spacing between successive domain releases; at least 1.
- `TIMEOUT_CYCLES`, default 1000000: lock-wait watchdog limit (timeout build only).

Ports:
- `clock`, in, 1: single clock for all logic.
- `reset`, in, 1: reset is synchronous and active-high.
- `i_locked`, in, `NUM_LOCKS`: raw asynchronous MMCM LOCKED signals.
- `o_pll_reset`, out, 1: drives MMCM RST, active-high.
- `o_reset`, out, `NUM_DOMAINS`: per-domain reset, active-high, registered. Bit 0 is released first.
- `o_all_ready`, out, 1: high only in RUN.
- `o_state`, out, 2: current state encoding (debug/LED).
- `o_fault`, out, `NUM_LOCKS`: sticky per-lock timeout flags.

## Operation
- Each `i_locked` bit passes through a `SYNC_STAGES` flop chain. Only the synchronised value `lk` is used.
- States, encoded 0–3:
  - PLL_RST: `o_pll_reset`=1. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
  - WAIT_LOCK: `o_pll_reset`=0 and all `o_reset`=1. When all `lk` bits are 1, clear the counter and go to RELEASE.
  - RELEASE: an index `k` starts at 0. Each time the counter reaches `HOLD_CYCLES`, clear `o_reset[k]`, increment `k`, and clear the counter. After clearing bit `NUM_DOMAINS-1`, go to RUN.
  - RUN: `o_all_ready`=1. Remain here while all `lk` bits are 1.
- Lock loss: if any `lk` bit is 0 in RELEASE or RUN, then at the next edge:
  - all `o_reset` bits return to 1;
  - `o_all_ready` returns to 0;
  - `k` and the counter are cleared;
  - the state goes to WAIT_LOCK.
  - Released domains are always re-reset; a partial sequence never resumes.
- Priority, highest first: `reset`, lock loss, timeout, normal transition.
- Counter width is `$clog2` of the largest cycle parameter, plus 1. It saturates and never wraps.
- Reset values:
  - state = PLL_RST; counter = 0; `k` = 0;
  - `o_pll_reset`=1; `o_reset`=all 1; `o_all_ready`=0; `o_fault`=0;
  - synchroniser flops = 0.

## Timing
- Lock rise to release of `o_reset[0]`: `SYNC_STAGES` + 1 + `HOLD_CYCLES` cycles.
- Release of bit `j` to release of bit `j+1`: exactly `HOLD_CYCLES` cycles.
- `o_all_ready` rises in the same cycle that `o_reset[NUM_DOMAINS-1]` falls.
- Lock fall to all `o_reset` high: `SYNC_STAGES` + 1 cycles. A single-cycle lock dropout is therefore caught.
- `reset` asserted mid-sequence: all outputs take their reset values at the next edge.
- All outputs are registered, with no combinational paths from inputs.

## Configuration
- `RESET_SEQUENCER_TIMEOUT_EN` defined:
  - WAIT_LOCK counts cycles.
  - When the count reaches `TIMEOUT_CYCLES`, `o_fault` is ORed with the inverse of `lk`, the counter is cleared, and the state goes to PLL_RST (retry).
  - `o_fault` clears only on `reset`.
- Macro undefined:
  - no watchdog; WAIT_LOCK waits indefinitely;
  - `o_fault` is tied to 0;
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `reset_sequencer_pkg`:
  - state typedef with the four states and fixed encodings 0–3;
  - counter-width helper function;
  - default parameter constants.
- Sub-module `bit_synchronizer`: parameter `STAGES`, one bit wide, synchronous reset. It is instantiated `NUM_LOCKS` times.

## Test plan
Configuration for all tests: `NUM_LOCKS`=3, `NUM_DOMAINS`=3, `SYNC_STAGES`=2, `PLL_RST_CYCLES`=8, `HOLD_CYCLES`=4, `TIMEOUT_CYCLES`=64.

- Power-up, locks 3'b111 from cycle 20:
  - `o_pll_reset` high for cycles 0–7;
  - `o_reset` goes 3'b111 → 3'b110 → 3'b100 → 3'b000 at 4-cycle spacing, the first fall at cycle 27;
  - `o_all_ready` rises with the last fall;
  - `o_state` goes 0, 1, 2, 3.
- RUN, `i_locked[1]` low for one cycle:
  - `o_reset`=3'b111 and `o_all_ready`=0 exactly 3 cycles later;
  - full re-release follows.
- Lock drop in RELEASE right after `o_reset[0]` falls: `o_reset[0]` is re-asserted, and the sequence restarts from bit 0.
- Timeout build, `i_locked[2]` stuck at 0:
  - after 64 cycles in WAIT_LOCK, `o_fault`=3'b100 and `o_pll_reset` pulses for 8 cycles;
  - the fault remains set after the locks later recover and RUN is reached.
- Non-timeout build, same stimulus: stays in WAIT_LOCK indefinitely with `o_fault`=0.
- `reset` pulsed in RUN: at the next edge, state=PLL_RST, `o_reset`=3'b111, `o_pll_reset`=1, `o_fault`=0.
